// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a framed big-endian byte stream into
// 32-bit words, writes them from word 0 up, and holds the CPU while loading.
module imem_loader #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              load_done,
  output logic              load_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CKSUM = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  logic [2:0]        state_q, state_d;
  logic              rx_ready_q, rx_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              load_err_q, load_err_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] last_idx_q, last_idx_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [7:0]        cksum_q, cksum_d;
  logic              accept;

  assign accept = rx_valid && rx_ready_q;

  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = load_done_q;
    load_err_d  = load_err_q;
    word_idx_d  = word_idx_q;
    last_idx_d  = last_idx_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
    cksum_d     = cksum_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d     = S_COUNT;
          cpu_hold_d  = 1'b1;
          load_done_d = 1'b0;
          load_err_d  = 1'b0;
        end
      end
      S_COUNT: begin
        if (accept) begin
          if (rx_data == 8'd0 || 32'(rx_data) > 32'(DEPTH)) begin
            state_d    = S_ERR;
            load_err_d = 1'b1;
          end else begin
            // Keep N-1 so the last-word compare fits in the index width.
            last_idx_d = ADDR_W'(rx_data - 8'd1);
            word_idx_d = '0;
            byte_cnt_d = '0;
            cksum_d    = '0;
            state_d    = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept) begin
          shift_d    = {shift_q[15:0], rx_data};
          cksum_d    = cksum_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_en_d   = 1'b1;
            wr_data_d = {shift_q, rx_data};
            wr_addr_d = word_idx_q;
            if (word_idx_q == last_idx_q) begin
              state_d = S_CKSUM;
            end else begin
              word_idx_d = word_idx_q + ADDR_W'(1);
            end
          end
        end
      end
      S_CKSUM: begin
        if (accept) begin
          if (rx_data == cksum_q) begin
            state_d     = S_DONE;
            cpu_hold_d  = 1'b0;
            load_done_d = 1'b1;
          end else begin
            state_d    = S_ERR;
            load_err_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Decoding the next state keeps rx_ready registered yet exact on the final accept.
    rx_ready_d = (state_d == S_COUNT) || (state_d == S_DATA) || (state_d == S_CKSUM);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rx_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
      word_idx_q  <= '0;
      last_idx_q  <= '0;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      cksum_q     <= '0;
    end else begin
      state_q     <= state_d;
      rx_ready_q  <= rx_ready_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
      word_idx_q  <= word_idx_d;
      last_idx_q  <= last_idx_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      cksum_q     <= cksum_d;
    end
  end

  assign rx_ready  = rx_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign cpu_hold  = cpu_hold_q;
  assign load_done = load_done_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of frames, hand-written corner sequences and
// random frames checked against a frame-level model of expected writes/status.
module tb_imem_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              cpu_hold;
  logic              load_done;
  logic              load_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [ADDR_W-1:0] got_addr[$];
  logic [31:0]       got_data[$];

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .cpu_hold(cpu_hold),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_en) begin
      got_addr.push_back(wr_addr);
      got_data.push_back(wr_data);
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string            name;
    logic [7:0]       cnt;
    int               nw;
    logic [3:0][31:0] w;
    bit               ck_explicit;
    logic [7:0]       ck_val;
    int               gap;
    int               mid_start;
    int               exp_writes;
    bit               exp_done;
    bit               exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] calc_ck(input logic [31:0] words[64], input int n);
    logic [7:0] x = '0;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++)
        x = x ^ 8'((words[i] >> (8 * j)) & 32'hFF);
    return x;
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap, input bit pulse_start, output bit ok);
    int g;
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    repeat (g) begin @(posedge clk); #1; end
    rx_data  = b;
    rx_valid = 1'b1;
    if (pulse_start) start = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 40 && !ok; t++) begin
      @(negedge clk);
      ok = rx_ready;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    rx_valid = 1'b0;
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL rx_accept: got no accept within 40 cycles required accept of %h", b);
    end
  endtask

  task automatic do_start(input string name);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({name, " start.cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({name, " start.load_done"}, 32'(load_done), 32'd0);
    check({name, " start.load_err"}, 32'(load_err), 32'd0);
    check({name, " start.rx_ready"}, 32'(rx_ready), 32'd1);
  endtask

  task automatic run_frame(input string name, input logic [7:0] cnt, input int nw,
                           input logic [31:0] words[64], input bit ck_explicit,
                           input logic [7:0] ck_val, input int gap, input int mid_start,
                           input int exp_writes, input bit exp_done, input bit exp_err);
    bit ok;
    logic [7:0] b;
    got_addr.delete();
    got_data.delete();
    do_start(name);
    send_byte(cnt, gap, 1'b0, ok);
    if (cnt == 8'd0 || int'(cnt) > DEPTH) begin
      check({name, " cnt.rx_ready"}, 32'(rx_ready), 32'd0);
    end else begin
      for (int i = 0; i < nw; i++) begin
        for (int j = 0; j < 4; j++) begin
          b = 8'((words[i] >> (24 - 8 * j)) & 32'hFF);
          send_byte(b, gap, (i * 4 + j) == mid_start, ok);
          if (j == 3) check({name, " wr_en.latency"}, 32'(wr_en), 32'd1);
        end
      end
      send_byte(ck_explicit ? ck_val : calc_ck(words, nw), gap, 1'b0, ok);
      check({name, " ck.rx_ready"}, 32'(rx_ready), 32'd0);
    end
    check({name, " load_done"}, 32'(load_done), 32'(exp_done));
    check({name, " load_err"}, 32'(load_err), 32'(exp_err));
    check({name, " cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
    repeat (2) @(negedge clk);
    check({name, " write_count"}, got_addr.size(), exp_writes);
    for (int i = 0; i < got_addr.size() && i < exp_writes; i++) begin
      check($sformatf("%s addr[%0d]", name, i), 32'(got_addr[i]), i);
      check($sformatf("%s data[%0d]", name, i), got_data[i], words[i]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " rx_ready"}, 32'(rx_ready), 32'd0);
    check({name, " wr_en"}, 32'(wr_en), 32'd0);
    check({name, " wr_addr"}, 32'(wr_addr), 32'd0);
    check({name, " wr_data"}, wr_data, 32'd0);
    check({name, " cpu_hold"}, 32'(cpu_hold), 32'd0);
    check({name, " load_done"}, 32'(load_done), 32'd0);
    check({name, " load_err"}, 32'(load_err), 32'd0);
  endtask

  vec_t tbl[7];
  logic [31:0] words[64];

  initial begin
    logic [3:0][31:0] base;
    bit ok;
    bit bad;
    bit valid;
    int n;
    logic [7:0] cnt;
    logic [7:0] ck;

    base = {32'h08000001, 32'h48220004, 32'h48020001, 32'h20080005};
    tbl[0] = '{"good4",   8'd4,  4,  base, 1'b0, 8'h00, 0, -1, 4,  1'b1, 1'b0};
    tbl[1] = '{"badck4",  8'd4,  4,  base, 1'b1, 8'h00, 0, -1, 4,  1'b0, 1'b1};
    tbl[2] = '{"recover", 8'd4,  4,  base, 1'b0, 8'h00, 0, -1, 4,  1'b1, 1'b0};
    tbl[3] = '{"cnt00",   8'h00, 0,  base, 1'b0, 8'h00, 0, -1, 0,  1'b0, 1'b1};
    tbl[4] = '{"cnt41",   8'h41, 0,  base, 1'b0, 8'h00, 0, -1, 0,  1'b0, 1'b1};
    tbl[5] = '{"single",  8'd1,  1,  {96'd0, 32'h48020001}, 1'b1, 8'h4B, 1, -1, 1, 1'b1, 1'b0};
    tbl[6] = '{"full64",  8'd64, 64, base, 1'b0, 8'h00, 0, -1, 64, 1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all_zero("reset");

    foreach (tbl[k]) begin
      for (int i = 0; i < 64; i++) words[i] = (i < 4) ? tbl[k].w[i] : (32'hC0DE0000 | 32'(i));
      run_frame(tbl[k].name, tbl[k].cnt, tbl[k].nw, words, tbl[k].ck_explicit, tbl[k].ck_val,
                tbl[k].gap, tbl[k].mid_start, tbl[k].exp_writes, tbl[k].exp_done, tbl[k].exp_err);
    end

    // start pulsed alongside a data byte must be ignored
    for (int i = 0; i < 4; i++) words[i] = base[i];
    run_frame("start_in_data", 8'd4, 4, words, 1'b0, 8'h00, 0, 5, 4, 1'b1, 1'b0);

    // reset after the 6th data byte of a 4-word frame
    got_addr.delete();
    got_data.delete();
    do_start("midreset");
    send_byte(8'd4, 0, 1'b0, ok);
    words[0] = 32'h11223344;
    words[1] = 32'h55667788;
    for (int j = 0; j < 6; j++) send_byte(8'((words[j / 4] >> (24 - 8 * (j % 4))) & 32'hFF), 0, 1'b0, ok);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all_zero("midreset");
    check("midreset writes", got_addr.size(), 1);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("midreset idle.rx_ready", 32'(rx_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    check("midreset idle.writes", got_addr.size(), 1);
    check("midreset idle.cpu_hold", 32'(cpu_hold), 32'd0);
    for (int i = 0; i < 4; i++) words[i] = base[i];
    run_frame("after_reset", 8'd4, 4, words, 1'b0, 8'h00, 0, -1, 4, 1'b1, 1'b0);

    // random frames against the frame-level model
    for (int r = 0; r < 24; r++) begin
      n = int'($urandom_range(1, 6));
      cnt = 8'(n);
      if ($urandom_range(0, 7) == 0) cnt = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(65, 255));
      valid = (cnt != 8'd0) && (int'(cnt) <= DEPTH);
      for (int i = 0; i < 64; i++) words[i] = $urandom;
      bad = ($urandom_range(0, 3) == 0);
      ck = calc_ck(words, n);
      if (bad) ck = ck ^ 8'($urandom_range(1, 255));
      run_frame($sformatf("rand%0d", r), cnt, n, words, 1'b1, ck, -1, -1,
                valid ? n : 0, valid && !bad, !(valid && !bad));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
